tmr_mc: RTL and testbench

- Multi-channel PWM/compare timer, parametrised in counter width, prescaler width and channel count.
- One shared up-counter with a programmable prescaler, programmable top value and one-shot mode. It drives ch_n compare channels with per-channel polarity and per-source masked interrupts.
- Attaches to the same simple peripheral bus (addr/we/wd/rd) as the other my_periph blocks.
- Drop-in successor for single-channel timers in SoC top levels.

---
 rtl/tmr_mc_pkg.sv | 34 +++
 rtl/tmr_mc_if.sv | 10 +
 rtl/tmr_mc_ch.sv | 32 +++
 rtl/tmr_mc.sv | 160 ++++++++++++++++
 tb/tb_tmr_mc.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_mc_pkg.sv
// Shared definitions for the tmr_mc multi-channel timer: register map,
// control-register layout and interrupt bit placement.
package tmr_mc_pkg;

    localparam logic [5:0] TMR_MC_CR   = 6'h00;
    localparam logic [5:0] TMR_MC_PSC  = 6'h04;
    localparam logic [5:0] TMR_MC_TOP  = 6'h08;
    localparam logic [5:0] TMR_MC_CNT  = 6'h0C;
    localparam logic [5:0] TMR_MC_IR   = 6'h10;
    localparam logic [5:0] TMR_MC_IE   = 6'h14;
    localparam logic [5:0] TMR_MC_POL  = 6'h18;
    localparam logic [5:0] TMR_MC_CAP  = 6'h1C;
    localparam logic [5:0] TMR_MC_CMP0 = 6'h20;

    typedef struct packed {
        logic os;
        logic ex;
        logic en;
    } cr_t;

    // IR/IE layout: bit 0 overflow, bits ch_n..1 compare, bit ch_n+1 capture
    function automatic int ir_cmp_idx(input int ch);
        return 1 + ch;
    endfunction

    function automatic int ir_cap_idx(input int ch_n);
        return ch_n + 1;
    endfunction

    function automatic int ir_width(input int ch_n);
        return ch_n + 2;
    endfunction

endpackage

// File: rtl/tmr_mc_if.sv
// Simple my_periph register bus: single-cycle writes, combinational reads.
interface tmr_mc_if;
    logic [5:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, we, wd, input rd);
    modport slave  (input addr, we, wd, output rd);
endinterface

// File: rtl/tmr_mc_ch.sv
// One compare channel: CMP register, match detect and registered
// polarity-adjusted PWM output.
module tmr_mc_ch #(
    parameter int tmr_w = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmp_we,
    input  logic [tmr_w-1:0] wd,
    input  logic [tmr_w-1:0] cnt,
    input  logic             tick,
    input  logic             pol,
    output logic [tmr_w-1:0] cmp,
    output logic             match,
    output logic             out
);

    assign match = tick && (cnt == cmp);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmp <= '0;
            out <= 1'b0;
        end else begin
            if (cmp_we) cmp <= wd;
            out <= (cnt < cmp) ^ pol;
        end
    end

endmodule

// File: rtl/tmr_mc.sv
// Multi-channel PWM/compare timer with shared prescaled up-counter.
// Define TMR_MC_CAPTURE_EN to build the tmr_in capture register.
module tmr_mc
    import tmr_mc_pkg::*;
#(
    parameter int tmr_w = 16,
    parameter int psc_w = 8,
    parameter int ch_n  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    tmr_mc_if.slave         bus,
    output logic            irq,
    input  logic            tmr_in,
    output logic [ch_n-1:0] tmr_out
);

    localparam int IR_W  = ir_width(ch_n);
    localparam int CAP_B = ir_cap_idx(ch_n);

    cr_t              cr;
    logic [psc_w-1:0] psc, pc;
    logic [tmr_w-1:0] top, cnt, cap;
    logic [IR_W-1:0]  ir, ie, ir_set, ir_clr, ie_mask;
    logic [ch_n-1:0]  pol, match, cmp_we;
    logic [tmr_w-1:0] cmp_q [ch_n];
    logic [2:0]       sync;
    logic             rise, src, tick, wrap, cap_evt;
    logic             wr_cr, wr_psc, wr_top, wr_cnt, wr_ir, wr_ie, wr_pol;
    logic [3:0]       word;
    logic             unused;

    assign word   = bus.addr[5:2];
    assign unused = ^{bus.addr[1:0], bus.wd};

    assign wr_cr  = bus.we && (word == TMR_MC_CR[5:2]);
    assign wr_psc = bus.we && (word == TMR_MC_PSC[5:2]);
    assign wr_top = bus.we && (word == TMR_MC_TOP[5:2]);
    assign wr_cnt = bus.we && (word == TMR_MC_CNT[5:2]);
    assign wr_ir  = bus.we && (word == TMR_MC_IR[5:2]);
    assign wr_ie  = bus.we && (word == TMR_MC_IE[5:2]);
    assign wr_pol = bus.we && (word == TMR_MC_POL[5:2]);

    always_comb begin
        cmp_we = '0;
        for (int i = 0; i < ch_n; i++)
            cmp_we[i] = bus.we && (word == TMR_MC_CMP0[5:2] + 4'(i));
    end

    // sync[1] is the synchroniser output; rise is registered one cycle later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[1:0], tmr_in};
            rise <= sync[1] & ~sync[2];
        end
    end

    assign src  = cr.ex ? rise : 1'b1;
    assign tick = cr.en && src && (pc == psc);
    assign wrap = tick && (cnt == top);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            pc  <= '0;
        end else if (!cr.en) begin
            cnt <= '0;
            pc  <= '0;
        end else if (wr_cnt) begin
            cnt <= bus.wd[tmr_w-1:0];
            pc  <= '0;
        end else begin
            if (src)  pc  <= (pc == psc) ? '0 : pc + psc_w'(1);
            // cnt above top runs on and wraps naturally without flagging overflow
            if (tick) cnt <= wrap ? '0 : cnt + tmr_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cr  <= '0;
            psc <= '0;
            top <= '1;
            ie  <= '0;
            pol <= '0;
        end else begin
            if (wr_cr)             cr     <= cr_t'(bus.wd[2:0]);
            else if (wrap && cr.os) cr.en <= 1'b0;
            if (wr_psc) psc <= bus.wd[psc_w-1:0];
            if (wr_top) top <= bus.wd[tmr_w-1:0];
            if (wr_ie)  ie  <= bus.wd[IR_W-1:0] & ie_mask;
            if (wr_pol) pol <= bus.wd[ch_n-1:0];
        end
    end

`ifdef TMR_MC_CAPTURE_EN
    assign cap_evt = rise & ~cr.ex;
    assign ie_mask = '1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        cap <= '0;
        else if (cap_evt) cap <= cnt;
    end
`else
    assign cap_evt = 1'b0;
    assign cap     = '0;
    assign ie_mask = ~(IR_W'(1) << CAP_B);
`endif

    assign ir_set = {cap_evt, match, wrap};
    assign ir_clr = wr_ir ? bus.wd[IR_W-1:0] : '0;

    // A hardware set in the same cycle as a software clear must win
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir  <= '0;
            irq <= 1'b0;
        end else begin
            ir  <= (ir & ~ir_clr) | ir_set;
            irq <= |(ir & ie);
        end
    end

    for (genvar i = 0; i < ch_n; i++) begin : g_ch
        tmr_mc_ch #(.tmr_w(tmr_w)) u_ch (
            .clk    (clk),
            .rstn   (rstn),
            .cmp_we (cmp_we[i]),
            .wd     (bus.wd[tmr_w-1:0]),
            .cnt    (cnt),
            .tick   (tick),
            .pol    (pol[i]),
            .cmp    (cmp_q[i]),
            .match  (match[i]),
            .out    (tmr_out[i])
        );
    end

    always_comb begin
        bus.rd = '0;
        case (word)
            TMR_MC_CR[5:2]:  bus.rd = 32'(cr);
            TMR_MC_PSC[5:2]: bus.rd = 32'(psc);
            TMR_MC_TOP[5:2]: bus.rd = 32'(top);
            TMR_MC_CNT[5:2]: bus.rd = 32'(cnt);
            TMR_MC_IR[5:2]:  bus.rd = 32'(ir);
            TMR_MC_IE[5:2]:  bus.rd = 32'(ie);
            TMR_MC_POL[5:2]: bus.rd = 32'(pol);
            TMR_MC_CAP[5:2]: bus.rd = 32'(cap);
            default: begin
                for (int i = 0; i < ch_n; i++)
                    if (word == TMR_MC_CMP0[5:2] + 4'(i)) bus.rd = 32'(cmp_q[i]);
            end
        endcase
    end

endmodule

// File: tb/tb_tmr_mc.sv
// Self-checking bench for tmr_mc: randomized PWM configurations checked
// against an arithmetic model of the counter, plus directed scenarios.
module tb_tmr_mc;
    import tmr_mc_pkg::*;

    localparam int TW  = 16;
    localparam int PW  = 8;
    localparam int CN  = 4;
    localparam int IRW = CN + 2;
`ifdef TMR_MC_CAPTURE_EN
    localparam logic [31:0] IE_MASK = 32'h3F;
`else
    localparam logic [31:0] IE_MASK = 32'h1F;
`endif

    logic          clk;
    logic          rstn;
    logic          irq;
    logic          tmr_in;
    logic [CN-1:0] tmr_out;
    int            n_checks;
    int            n_fail;

    tmr_mc_if bus ();

    tmr_mc #(.tmr_w(TW), .psc_w(PW), .ch_n(CN)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .irq     (irq),
        .tmr_in  (tmr_in),
        .tmr_out (tmr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter value after n clock edges since enable: one tick per P+1 clocks
    function automatic int mcnt(input int n, input int p, input int t);
        return (n / (p + 1)) % (t + 1);
    endfunction

    function automatic logic [IRW-1:0] m_ir(input int n, input int p, input int t,
                                            input int unsigned c [CN]);
        logic [IRW-1:0] r;
        int ticks;
        r = '0;
        ticks = n / (p + 1);
        if (ticks >= t + 1) r[0] = 1'b1;
        for (int i = 0; i < CN; i++)
            if (c[i] <= 32'(t) && ticks >= int'(c[i]) + 1) r[1 + i] = 1'b1;
        return r;
    endfunction

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wd   = d;
        bus.we   = 1'b1;
        @(negedge clk);
        bus.we   = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        bus.addr = a;
        #1 d = bus.rd;
    endtask

    task automatic setup(input int p, input int t, input int unsigned c [CN],
                         input logic [CN-1:0] pol, input logic [31:0] ie);
        wr(TMR_MC_CR, 32'h0);
        wr(TMR_MC_PSC, 32'(p));
        wr(TMR_MC_TOP, 32'(t));
        for (int i = 0; i < CN; i++) wr(TMR_MC_CMP0 + 6'(4 * i), c[i]);
        wr(TMR_MC_POL, 32'(pol));
        wr(TMR_MC_IE, ie);
        wr(TMR_MC_IR, 32'hFFFF_FFFF);
    endtask

    task automatic pulse_in();
        @(negedge clk);
        tmr_in = 1'b1;
        repeat (3) @(negedge clk);
        tmr_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        rstn = 1'b0; tmr_in = 1'b0;
        bus.addr = '0; bus.we = 1'b0; bus.wd = '0;
        #1;
        n_checks++;
        if (tmr_out !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: tmr_out=%0h irq=%0b, required 0 0", tmr_out, irq);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int w = 0; w < 16; w++) begin
            bus_rd(6'(w * 4), v);
            e = (w == 2) ? 32'h0000_FFFF : 32'h0;
            n_checks++;
            if (v !== e) begin
                n_fail++;
                $display("FAIL reset_reg@%0h: got %0h, required %0h", w * 4, v, e);
            end
        end
    endtask

    task automatic test_regs();
        logic [5:0]  addrs [10];
        logic [31:0] masks [10];
        logic [31:0] d, v;
        addrs = '{TMR_MC_PSC, TMR_MC_TOP, TMR_MC_POL, TMR_MC_IE, TMR_MC_CR,
                  6'h20, 6'h24, 6'h28, 6'h2C, 6'h30};
        masks = '{32'hFF, 32'hFFFF, 32'hF, IE_MASK, 32'h6,
                  32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h0};
        for (int k = 0; k < 10; k++) begin
            d = $urandom;
            if (addrs[k] == TMR_MC_CR) d = d & 32'h6;
            wr(addrs[k], d);
            bus_rd(addrs[k], v);
            n_checks++;
            if (v !== (d & masks[k])) begin
                n_fail++;
                $display("FAIL reg_rw@%0h: got %0h, required %0h", addrs[k], v, d & masks[k]);
            end
        end
        wr(TMR_MC_CR, 32'h0);
    endtask

    task automatic run_pwm(input int p, input int t, input int unsigned c [CN],
                           input logic [CN-1:0] pol, input logic [31:0] ie, input bit duty);
        logic [31:0]    v;
        logic [CN-1:0]  eo;
        logic [IRW-1:0] eir;
        int nmax, prev, high;
        setup(p, t, c, pol, ie);
        wr(TMR_MC_CR, 32'h1);
        nmax = 2 * (t + 1) * (p + 1) + 4;
        high = 0;
        for (int n = 0; n <= nmax; n++) begin
            bus_rd(TMR_MC_CNT, v);
            n_checks++;
            if (v !== 32'(mcnt(n, p, t))) begin
                n_fail++;
                $display("FAIL pwm_cnt n=%0d P=%0d T=%0d: got %0d, required %0d", n, p, t, v, mcnt(n, p, t));
            end
            prev = (n == 0) ? 0 : mcnt(n - 1, p, t);
            for (int i = 0; i < CN; i++) eo[i] = (32'(prev) < c[i]) ^ pol[i];
            n_checks++;
            if (tmr_out !== eo) begin
                n_fail++;
                $display("FAIL pwm_out n=%0d: got %b, required %b", n, tmr_out, eo);
            end
            if (n >= 10 && n < 20) high += int'(tmr_out[0]);
            @(negedge clk);
        end
        eir = m_ir(nmax + 1, p, t, c);
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v !== 32'(eir)) begin
            n_fail++;
            $display("FAIL pwm_ir P=%0d T=%0d: got %0h, required %0h", p, t, v, eir);
        end
        n_checks++;
        if (irq !== |(m_ir(nmax, p, t, c) & ie[IRW-1:0])) begin
            n_fail++;
            $display("FAIL pwm_irq: got %0b, required %0b", irq, |(m_ir(nmax, p, t, c) & ie[IRW-1:0]));
        end
        if (duty) begin
            n_checks++;
            if (high !== 3) begin
                n_fail++;
                $display("FAIL pwm_duty: got %0d high cycles of 10, required 3", high);
            end
        end
        wr(TMR_MC_CR, 32'h0);
    endtask

    task automatic test_pwm();
        int unsigned c [CN];
        int p, t;
        c = '{3, 0, 10, 7};
        run_pwm(0, 9, c, 4'b0000, 32'h1, 1'b1);
        c = '{2, 4, 5, 1};
        run_pwm(3, 4, c, 4'b1010, 32'h1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            p = $urandom_range(3, 0);
            t = $urandom_range(15, 3);
            for (int i = 0; i < CN; i++) c[i] = $urandom_range(t + 2, 0);
            run_pwm(p, t, c, 4'($urandom), $urandom & IE_MASK, 1'b0);
        end
    endtask

    task automatic test_one_shot();
        int unsigned c [CN];
        logic [31:0] v;
        c = '{9, 9, 9, 9};
        setup(0, 5, c, 4'b0, 32'h0);
        wr(TMR_MC_CR, 32'h5);
        repeat (3) @(negedge clk);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL os_run_cnt: got %0d, required 3", v); end
        repeat (7) @(negedge clk);
        bus_rd(TMR_MC_CR, v);
        n_checks++;
        if (v !== 32'h4) begin n_fail++; $display("FAIL os_cr: got %0h, required 4", v); end
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[0] !== 1'b1) begin n_fail++; $display("FAIL os_ir0: got %0b, required 1", v[0]); end
        repeat (20) @(negedge clk);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL os_cnt_hold: got %0d, required 0", v); end
    endtask

    task automatic test_cr_rewrite();
        int unsigned c [CN];
        logic [31:0] v;
        c = '{0, 0, 0, 0};
        setup(1, 15, c, 4'b0, 32'h0);
        wr(TMR_MC_CR, 32'h1);
        repeat (3) @(negedge clk);
        wr(TMR_MC_CR, 32'h1);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'(mcnt(5, 1, 15))) begin
            n_fail++;
            $display("FAIL cr_rewrite_cnt: got %0d, required %0d", v, mcnt(5, 1, 15));
        end
        repeat (6) @(negedge clk);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'(mcnt(11, 1, 15))) begin
            n_fail++;
            $display("FAIL cr_rewrite_cnt2: got %0d, required %0d", v, mcnt(11, 1, 15));
        end
    endtask

    task automatic test_external();
        int unsigned c [CN];
        logic [31:0] v;
        int k;
        c = '{9, 9, 9, 9};
        for (int r = 0; r < 3; r++) begin
            k = (r == 0) ? 7 : $urandom_range(10, 1);
            setup(0, 2, c, 4'b0, 32'h0);
            wr(TMR_MC_CR, 32'h3);
            repeat (20) @(negedge clk);
            bus_rd(TMR_MC_CNT, v);
            n_checks++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL ext_idle_cnt: got %0d, required 0", v); end
            for (int j = 0; j < k; j++) pulse_in();
            repeat (6) @(negedge clk);
            bus_rd(TMR_MC_CNT, v);
            n_checks++;
            if (v !== 32'(k % 3)) begin
                n_fail++;
                $display("FAIL ext_cnt pulses=%0d: got %0d, required %0d", k, v, k % 3);
            end
            bus_rd(TMR_MC_IR, v);
            n_checks++;
            if (v[0] !== (k >= 3)) begin
                n_fail++;
                $display("FAIL ext_ir0 pulses=%0d: got %0b, required %0b", k, v[0], k >= 3);
            end
        end
        wr(TMR_MC_CR, 32'h0);
    endtask

    task automatic test_ir_race();
        int unsigned c [CN];
        logic [31:0] v;
        int t;
        t = $urandom_range(8, 3);
        c = '{15, 15, 15, 15};
        setup(0, t, c, 4'b0, 32'h0);
        wr(TMR_MC_CR, 32'h1);
        repeat (t - 1) @(negedge clk);
        wr(TMR_MC_IR, 32'h1);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL race_align_cnt: got %0d, required 0", v); end
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[0] !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %0b, required 1", v[0]); end
        wr(TMR_MC_CR, 32'h0);
        wr(TMR_MC_IE, 32'h1);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq_on: got %0b, required 1", irq); end
        wr(TMR_MC_IR, 32'h1);
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[0] !== 1'b0) begin n_fail++; $display("FAIL race_clear: got %0b, required 0", v[0]); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq_lag: got %0b, required 1", irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL race_irq_drop: got %0b, required 0", irq); end
    endtask

    task automatic test_above_top();
        int unsigned c [CN];
        logic [31:0] v;
        c = '{7, 7, 7, 7};
        setup(0, 5, c, 4'b0, 32'h0);
        wr(TMR_MC_CR, 32'h1);
        wr(TMR_MC_CNT, 32'hFFFC);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'hFFFC) begin n_fail++; $display("FAIL cnt_load: got %0h, required fffc", v); end
        repeat (4) @(negedge clk);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL natural_wrap_cnt: got %0h, required 0", v); end
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[0] !== 1'b0) begin n_fail++; $display("FAIL natural_wrap_ir0: got %0b, required 0", v[0]); end
        repeat (5) @(negedge clk);
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'd5) begin n_fail++; $display("FAIL resume_cnt: got %0d, required 5", v); end
        @(negedge clk);
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[0] !== 1'b1) begin n_fail++; $display("FAIL resume_ir0: got %0b, required 1", v[0]); end
        wr(TMR_MC_CR, 32'h0);
    endtask

    task automatic test_capture();
        int unsigned c [CN];
        logic [31:0] v;
        int k;
        k = $urandom_range(10, 3);
        c = '{0, 0, 0, 0};
        setup(0, 32'hFFFF, c, 4'b0, 32'h0);
        wr(TMR_MC_CR, 32'h1);
        repeat (k) @(negedge clk);
        tmr_in = 1'b1;
        repeat (8) @(negedge clk);
        tmr_in = 1'b0;
        bus_rd(TMR_MC_CAP, v);
`ifdef TMR_MC_CAPTURE_EN
        // Edge seen 2 flops + 1 detect cycle after tmr_in rises; CNT = k+3 then
        n_checks++;
        if (v !== 32'(k + 3)) begin n_fail++; $display("FAIL cap_value: got %0d, required %0d", v, k + 3); end
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[CN+1] !== 1'b1) begin n_fail++; $display("FAIL cap_ir: got %0b, required 1", v[CN+1]); end
`else
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL cap_absent: got %0h, required 0", v); end
        bus_rd(TMR_MC_IR, v);
        n_checks++;
        if (v[CN+1] !== 1'b0) begin n_fail++; $display("FAIL cap_ir_absent: got %0b, required 0", v[CN+1]); end
`endif
        wr(TMR_MC_CR, 32'h0);
    endtask

    task automatic test_reset_mid();
        int unsigned c [CN];
        logic [31:0] v;
        c = '{0, 0, 0, 0};
        setup(0, 3, c, 4'hF, 32'h1);
        wr(TMR_MC_CR, 32'h1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1 || tmr_out !== 4'hF) begin
            n_fail++;
            $display("FAIL pre_reset: irq=%0b tmr_out=%0h, required 1 f", irq, tmr_out);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (irq !== 1'b0 || tmr_out !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset_out: irq=%0b tmr_out=%0h, required 0 0", irq, tmr_out);
        end
        bus_rd(TMR_MC_TOP, v);
        n_checks++;
        if (v !== 32'hFFFF) begin n_fail++; $display("FAIL mid_reset_top: got %0h, required ffff", v); end
        bus_rd(TMR_MC_CNT, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0h, required 0", v); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_regs();
        test_pwm();
        test_one_shot();
        test_cr_rewrite();
        test_external();
        test_ir_race();
        test_above_top();
        test_capture();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
